// File: rtl/target1v_decode.sv
// Recovers the 6-bit offset code from a 1 V accumulator target word: value = (target - BASE) / STEP.
// Optional macro TARGET1V_DECODE_ROUND_EN rounds the quotient to nearest instead of truncating.
module target1v_decode #(
  parameter logic [31:0] BASE    = 32'd429482970,
  parameter logic [31:0] STEP    = 32'd430,
  parameter int          VALUE_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        target,
  output logic               busy,
  output logic               done,
  output logic [VALUE_W-1:0] value,
  output logic [31:0]        remainder,
  output logic               exact,
  output logic               underflow,
  output logic               overflow
);

  typedef enum logic [1:0] {IDLE, SUB, DIV, DONE} state_t;

  localparam logic [32:0] STEP33 = {1'b0, STEP};
  localparam logic [32:0] MAXQ   = 33'((34'd1 << VALUE_W) - 34'd1);

  state_t      state, state_nxt;
  logic [31:0] tgt, dividend, quot, rem;
  logic [4:0]  cnt;
  logic [32:0] diff, r_shift, r_next, q_fin;
  logic [31:0] q_next;
  logic        ge, ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SUB;
      SUB:  state_nxt = diff[32] ? DONE : DIV;
      DIV:  if (cnt == 5'd0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step; the final step feeds the output registers directly.
  always_comb begin
    diff    = {1'b0, tgt} - {1'b0, BASE};
    r_shift = {rem, dividend[cnt]};
    ge      = (r_shift >= STEP33);
    r_next  = ge ? (r_shift - STEP33) : r_shift;
    q_next  = quot;
    q_next[cnt] = ge;
`ifdef TARGET1V_DECODE_ROUND_EN
    q_fin   = {1'b0, q_next} + 33'({r_next, 1'b0} >= {1'b0, STEP33});
`else
    q_fin   = {1'b0, q_next};
`endif
    ovf     = (q_fin > MAXQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt       <= '0;
      dividend  <= '0;
      quot      <= '0;
      rem       <= '0;
      cnt       <= '0;
      value     <= '0;
      remainder <= '0;
      exact     <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) tgt <= target;
        SUB: begin
          dividend <= diff[31:0];
          rem      <= '0;
          quot     <= '0;
          cnt      <= 5'd31;
          if (diff[32]) begin
            value     <= '0;
            remainder <= '0;
            exact     <= 1'b0;
            underflow <= 1'b1;
            overflow  <= 1'b0;
          end
        end
        DIV: begin
          rem  <= r_next[31:0];
          quot <= q_next;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            value     <= ovf ? '1 : q_fin[VALUE_W-1:0];
            remainder <= r_next[31:0];
            exact     <= (r_next == 33'd0) && !ovf;
            underflow <= 1'b0;
            overflow  <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_target1v_decode.sv
// Directed self-checking bench for target1v_decode: latency, arithmetic, boundaries, handshake and reset abort.
module tb_target1v_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] target = '0;
  logic        busy, done, exact, underflow, overflow;
  logic [5:0]  value;
  logic [31:0] remainder;

  int checks = 0;
  int errors = 0;
  int lat, busycnt;
  logic [40:0] got, exp;

`ifdef TARGET1V_DECODE_ROUND_EN
  localparam logic [5:0] EXP_RND5 = 6'd6;
  localparam logic       EXP_OVF_EDGE = 1'b1;
`else
  localparam logic [5:0] EXP_RND5 = 6'd5;
  localparam logic       EXP_OVF_EDGE = 1'b0;
`endif

  target1v_decode dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .busy(busy), .done(done), .value(value), .remainder(remainder),
    .exact(exact), .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Launches one request and stops at the negedge inside the done cycle (bounded wait).
  task automatic run_op(input logic [31:0] t);
    @(negedge clk); start = 1'b1; target = t;
    @(negedge clk); start = 1'b0; target = 32'hdead_beef;
    lat = 1; busycnt = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) busycnt++;
      @(negedge clk); lat++;
    end
    if (busy === 1'b1) busycnt++;
    if (lat >= 60) begin
      checks++; errors++;
      $display("[TB] FAIL timeout: no done for target %0d", t);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, value, remainder, exact, underflow, overflow} !== 43'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected 0", {busy, done, value, remainder, exact, underflow, overflow});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got busy/done %b expected 00", {busy, done});
    end
  endtask

  task automatic test_basic;
    run_op(32'd429485120);
    checks++;
    if (lat !== 34) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 34", lat); end
    checks++;
    if (busycnt !== 34) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 34", busycnt); end
    got = {value, remainder, exact, underflow, overflow};
    exp = {6'd5, 32'd0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL basic_result: got %h expected %h", got, exp); end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, value, remainder, exact} !== {1'b0, 1'b0, 6'd5, 32'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL hold_after_done: got %h expected %h", {busy, done, value, remainder, exact}, {1'b0, 1'b0, 6'd5, 32'd0, 1'b1});
    end
  endtask

  task automatic test_remainder;
    run_op(32'd429485420);
    got = {value, remainder, exact, underflow, overflow};
    exp = {EXP_RND5, 32'd300, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL remainder_result: got %h expected %h", got, exp); end
  endtask

  task automatic test_boundaries;
    logic [31:0] tv [5] = '{32'd429510060, 32'd429510490, 32'd429482970, 32'd429510275, 32'hffff_ffff};
    logic [40:0] ev [5];
    ev[0] = {6'd63, 32'd0,   1'b1, 1'b0, 1'b0};
    ev[1] = {6'd63, 32'd0,   1'b0, 1'b0, 1'b1};
    ev[2] = {6'd0,  32'd0,   1'b1, 1'b0, 1'b0};
    ev[3] = {6'd63, 32'd215, 1'b0, 1'b0, EXP_OVF_EDGE};
    ev[4] = {6'd63, 32'd185, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_op(tv[i]);
      got = {value, remainder, exact, underflow, overflow};
      checks++;
      if (got !== ev[i]) begin
        errors++;
        $display("[TB] FAIL boundary_%0d: got %h expected %h", i, got, ev[i]);
      end
    end
  endtask

  task automatic test_underflow;
    run_op(32'd0);
    checks++;
    if (lat !== 2 || busycnt !== 2) begin
      errors++;
      $display("[TB] FAIL underflow_latency: got lat %0d busy %0d expected 2 2", lat, busycnt);
    end
    got = {value, remainder, exact, underflow, overflow};
    exp = {6'd0, 32'd0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL underflow_result: got %h expected %h", got, exp); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); start = 1'b1; target = 32'd429485120;
    @(negedge clk); start = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      start  = (lat == 10);
      target = (lat == 10) ? 32'd0 : 32'd429510490;
      @(negedge clk); lat++;
    end
    start = 1'b0;
    checks++;
    if (lat !== 34) begin errors++; $display("[TB] FAIL ignored_start_latency: got %0d expected 34", lat); end
    got = {value, remainder, exact, underflow, overflow};
    exp = {6'd5, 32'd0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL ignored_start_result: got %h expected %h", got, exp); end
    run_op(32'd429485420);
    checks++;
    if (lat !== 34) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 34", lat); end
    got = {value, remainder, exact, underflow, overflow};
    exp = {EXP_RND5, 32'd300, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL b2b_result: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk); start = 1'b1; target = 32'd429510060;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, value, remainder, exact, underflow, overflow} !== 43'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_clear: got %h expected 0", {busy, done, value, remainder, exact, underflow, overflow});
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || value !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_abort: got activity %0d value %0d expected 0 0", seen, value);
    end
    run_op(32'd429485120);
    got = {value, remainder, exact, underflow, overflow};
    exp = {6'd5, 32'd0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (lat !== 34 || got !== exp) begin
      errors++;
      $display("[TB] FAIL reset_mid_restart: got lat %0d result %h expected 34 %h", lat, got, exp);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_remainder;
    test_boundaries;
    test_underflow;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
